// File: rtl/vector_defn.sv
// vector_defn
// Registered vector-slicing and bit-ordering stage for one W-bit word.
// A valid word is captured on the rising clock edge. Its fields then appear
// on the outputs one cycle later and stay there until the next valid word.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset, sampled on clk
//   in_valid  num1 carries a word this cycle
//   num1      input word [W-1:0]
//   out_valid registered copy of in_valid
//   res1      MSB of the captured word
//   res2      low half of the captured word [W/2-1:0]
//   res3      captured word on an ascending-index bus [0:W-1]
//   res_rev   bit-reversed captured word
//   res_par   XOR-reduction (even parity) of the captured word
//   res_ones  number of 1 bits in the captured word, range 0..W
module vector_defn #(
  parameter int W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [W-1:0]               num1,
  output logic                       out_valid,
  output logic                       res1,
  output logic [W/2-1:0]             res2,
  output logic [0:W-1]               res3,
  output logic [W-1:0]               res_rev,
  output logic                       res_par,
  output logic [$clog2(W+1)-1:0]     res_ones
);

  localparam int H  = W / 2;
  localparam int OW = $clog2(W + 1);

  logic [W-1:0]  next_rev;
  logic [OW-1:0] next_ones;

  // Mirror the bit order and count the ones of the incoming word. Both are
  // purely combinational on num1 and only feed the capture registers, so no
  // input reaches an output without passing through a flop.
  always_comb begin
    next_rev  = '0;
    next_ones = '0;
    for (int i = 0; i < W; i++) begin
      next_rev[i] = num1[W-1-i];
      next_ones   = next_ones + OW'(num1[i]);
    end
  end

  // Capture registers. out_valid follows in_valid every edge, while the
  // result fields load only on a valid word and otherwise hold, so garbage on
  // num1 between words never disturbs them. Reset clears everything and wins
  // over a simultaneous valid word, which is simply dropped.
  // res3 takes num1 by plain vector assignment: the leftmost bit goes to the
  // leftmost position, so res3[0] receives the MSB and the numeric value is
  // unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res1      <= 1'b0;
      res2      <= '0;
      res3      <= '0;
      res_rev   <= '0;
      res_par   <= 1'b0;
      res_ones  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        res1     <= num1[W-1];
        res2     <= num1[H-1:0];
        res3     <= num1;
        res_rev  <= next_rev;
        res_par  <= ^num1;
        res_ones <= next_ones;
      end
    end
  end

endmodule

// File: tb/tb_vector_defn.sv
// tb_vector_defn
// Self-checking bench for vector_defn with W = 8. A table of directed words
// with hand-computed fields is applied one per cycle, followed by short
// hand-written sequences for reset behaviour and ascending-bus bit placement.
module tb_vector_defn;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] num1;
  logic         out_valid;
  logic         res1;
  logic [3:0]   res2;
  logic [0:W-1] res3;
  logic [W-1:0] res_rev;
  logic         res_par;
  logic [3:0]   res_ones;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic       valid;
    logic [7:0] num;
    logic       e_valid;
    logic       e_r1;
    logic [3:0] e_r2;
    logic [7:0] e_r3;
    logic [7:0] e_rev;
    logic       e_par;
    logic [3:0] e_ones;
  } vec_t;

  vec_t vecs[11];

  vector_defn #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .num1     (num1),
    .out_valid(out_valid),
    .res1     (res1),
    .res2     (res2),
    .res3     (res3),
    .res_rev  (res_rev),
    .res_par  (res_par),
    .res_ones (res_ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, let one rising edge pass, then settle
  // 1 time unit so outputs are sampled away from the active edge.
  task automatic applyStimulus(input logic rst, input logic valid, input logic [7:0] num);
    @(negedge clk);
    rst_n    = rst;
    in_valid = valid;
    num1     = num;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic ev, input logic e1, input logic [3:0] e2,
                          input logic [7:0] e3, input logic [7:0] erev, input logic ep,
                          input logic [3:0] eo);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'(ev));
    checkOutput({tag, " res1"},      32'(res1),      32'(e1));
    checkOutput({tag, " res2"},      32'(res2),      32'(e2));
    checkOutput({tag, " res3"},      32'(res3),      32'(e3));
    checkOutput({tag, " res_rev"},   32'(res_rev),   32'(erev));
    checkOutput({tag, " res_par"},   32'(res_par),   32'(ep));
    checkOutput({tag, " res_ones"},  32'(res_ones),  32'(eo));
  endtask

  initial begin
    //          valid num    ev    r1    r2    r3     rev    par   ones
    vecs[0]  = '{1'b1, 8'hFA, 1'b1, 1'b1, 4'hA, 8'hFA, 8'h5F, 1'b0, 4'd6};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'hA, 8'hFA, 8'h5F, 1'b0, 4'd6};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'hA, 8'hFA, 8'h5F, 1'b0, 4'd6};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 4'hA, 8'hFA, 8'h5F, 1'b0, 4'd6};
    vecs[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 4'd0};
    vecs[5]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 4'hF, 8'hFF, 8'hFF, 1'b0, 4'd8};
    vecs[6]  = '{1'b1, 8'h81, 1'b1, 1'b1, 4'h1, 8'h81, 8'h81, 1'b0, 4'd2};
    vecs[7]  = '{1'b1, 8'h07, 1'b1, 1'b0, 4'h7, 8'h07, 8'hE0, 1'b1, 4'd3};
    vecs[8]  = '{1'b1, 8'h3C, 1'b1, 1'b0, 4'hC, 8'h3C, 8'h3C, 1'b0, 4'd4};
    vecs[9]  = '{1'b1, 8'h80, 1'b1, 1'b1, 4'h0, 8'h80, 8'h01, 1'b1, 4'd1};
    vecs[10] = '{1'b0, 8'h5A, 1'b0, 1'b1, 4'h0, 8'h80, 8'h01, 1'b1, 4'd1};

    rst_n    = 1'b0;
    in_valid = 1'b1;
    num1     = 8'hFF;

    // Reset held two cycles while a valid all-ones word is presented.
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b0, 1'b1, 8'hFF);
      checkAll($sformatf("reset%0d", c), 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 4'd0);
    end

    // Table-driven vectors, one edge each, results visible right after it.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b1, vecs[i].valid, vecs[i].num);
      checkAll($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_r1, vecs[i].e_r2,
               vecs[i].e_r3, vecs[i].e_rev, vecs[i].e_par, vecs[i].e_ones);
    end

    // Ascending bus placement: res3[0] must be the MSB of the captured word.
    applyStimulus(1'b1, 1'b1, 8'hFA);
    checkOutput("res3[0] of FA", 32'(res3[0]), 32'd1);
    checkOutput("res3[7] of FA", 32'(res3[7]), 32'd0);
    checkOutput("res3[5] of FA", 32'(res3[5]), 32'd0);
    checkOutput("res3[4] of FA", 32'(res3[4]), 32'd1);

    // Reset on the same edge as a valid word: everything clears, word dropped.
    applyStimulus(1'b0, 1'b1, 8'h01);
    checkAll("midreset", 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b0, 8'hFF);
    checkAll("postreset", 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 4'd0);

    // Back-to-back after reset release to confirm capture resumes at once.
    applyStimulus(1'b1, 1'b1, 8'h01);
    checkAll("resume", 1'b1, 1'b0, 4'h1, 8'h01, 8'h80, 1'b1, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/vector_defn.md
Name: vector_defn

Overview:
- Registered vector-slicing and bit-ordering unit for one W-bit input word.
- Produces the word's MSB, its low half, the word re-indexed into an ascending-range bus, and derived fields: bit-reversed word, even parity, population count.
- Used as a leaf formatting stage between a data source and downstream logic that wants ascending bit numbering or sliced fields.
- One clock, one-cycle latency, valid-qualified.

Parameters:
- W, 8, input word width; even, at least 2.
- H, W/2, low-slice width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  num1 is valid this cycle
- num1  input  W [W-1:0]  input word
- out_valid  output  1  registered in_valid
- res1  output  1  MSB of captured word
- res2  output  H [H-1:0]  low half of captured word
- res3  output  W [0:W-1]  captured word on ascending-index bus
- res_rev  output  W [W-1:0]  bit-reversed captured word
- res_par  output  1  XOR-reduction of captured word
- res_ones  output  clog2(W+1)  count of 1 bits in captured word

Behaviour:
- All state updates on rising clk only. No combinational input-to-output paths.
- rst_n is sampled on clk.
  - rst_n=0: every output register goes to 0 on that edge, including out_valid. All other inputs are ignored.
  - Reset overrides a simultaneous in_valid.
  - Reset mid-stream discards the word in flight.
- Capture rule, rst_n=1:
  - Every edge: out_valid <= in_valid.
  - in_valid=1: all res* outputs update from num1 on that edge.
  - in_valid=0: all res* outputs hold their previous values.
- Latency: one cycle. Back-to-back valid words give back-to-back results; throughput is 1 word per cycle.
- Field definitions, with n = num1 at capture:
  - res1 = n[W-1].
  - res2 = n[H-1:0].
  - res3[i] = n[W-1-i] for i = 0..W-1. res3 carries the same numeric value as n, so res3[0] is the MSB.
  - res_rev[i] = n[W-1-i], i.e. the value with bit order mirrored.
  - res_par = XOR of all bits of n. It is 1 when the count of ones is odd.
  - res_ones = number of 1 bits, unsigned. Range 0..W, with no wrap because the width is clog2(W+1).
- Boundary values:
  - n = 0: res1 = 0, res2 = 0, res3 = 0, res_rev = 0, res_par = 0, res_ones = 0.
  - n = all ones: res_ones = W, res_par = W mod 2 (0 for W = 8).
- X on num1 while in_valid=0 must not disturb the held outputs.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 and num1=8'hFF -> all outputs 0, out_valid 0.
- Single word: num1=8'hFA with in_valid=1 for 1 cycle -> next cycle:
  - out_valid=1, res1=1, res2=4'hA.
  - res3 value 8'hFA, with res3[0]=1 and res3[7]=0.
  - res_rev=8'h5F, res_par=0, res_ones=6.
- Hold: after 8'hFA, drive in_valid=0 and num1=8'h00 for 3 cycles -> out_valid=0; res* stay at the 8'hFA values.
- Back-to-back: 8'h00, 8'hFF, 8'h81 on consecutive valid cycles -> one cycle later, consecutive results:
  - 8'h00: res1=0, res2=0, res_ones=0, res_par=0.
  - 8'hFF: res1=1, res2=4'hF, res_ones=8, res_par=0.
  - 8'h81: res1=1, res2=4'h1, res_rev=8'h81, res_ones=2.
- Reset mid-stream: in_valid=1 with num1=8'h01, and rst_n=0 on the same edge -> all outputs 0; the word is not captured.
- Odd parity: num1=8'h07 -> res_par=1, res_ones=3, res_rev=8'hE0, res2=4'h7, res1=0.
